// File: rtl/taillight_monitor.sv
// Receive-side checker for the six tail-light lamp lines: follows the legal left/right
// sweep sequences, counts completed sweeps per side and flags illegal patterns.
module taillight_monitor #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             la,
   input  logic             lb,
   input  logic             lc,
   input  logic             ra,
   input  logic             rb,
   input  logic             rc,
   input  logic             clr_err,
   input  logic             clr_cnt,
   output logic             left_active,
   output logic             right_active,
   output logic             left_done,
   output logic             right_done,
   output logic [CNT_W-1:0] left_count,
   output logic [CNT_W-1:0] right_count,
   output logic             err,
   output logic             err_pulse
);

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      L1   = 4'd1,
      L2   = 4'd2,
      L3   = 4'd3,
      R1   = 4'd4,
      R2   = 4'd5,
      R3   = 4'd6,
      ERR  = 4'd7,
      SYNC = 4'd8
   } state_t;

   localparam logic [5:0] P_OFF = 6'b000000;
   localparam logic [5:0] P_L1  = 6'b100000;
   localparam logic [5:0] P_L2  = 6'b110000;
   localparam logic [5:0] P_L3  = 6'b111000;
   localparam logic [5:0] P_R1  = 6'b000100;
   localparam logic [5:0] P_R2  = 6'b000110;
   localparam logic [5:0] P_R3  = 6'b000111;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] left_cnt_q, left_cnt_d;
   logic [CNT_W-1:0] right_cnt_q, right_cnt_d;
   logic             left_done_q, left_done_d;
   logic             right_done_q, right_done_d;
   logic             err_pulse_q, err_pulse_d;
   logic [5:0]       p;

   assign p = {la, lb, lc, ra, rb, rc};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         left_cnt_q   <= '0;
         right_cnt_q  <= '0;
         left_done_q  <= 1'b0;
         right_done_q <= 1'b0;
         err_pulse_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         left_cnt_q   <= left_cnt_d;
         right_cnt_q  <= right_cnt_d;
         left_done_q  <= left_done_d;
         right_done_q <= right_done_d;
         err_pulse_q  <= err_pulse_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      left_done_d  = 1'b0;
      right_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (p == P_OFF)     state_d = IDLE;
            else if (p == P_L1) state_d = L1;
            else if (p == P_R1) state_d = R1;
            else                state_d = ERR;
         end
         L1:   state_d = (p == P_L2) ? L2 : ERR;
         L2:   state_d = (p == P_L3) ? L3 : ERR;
         L3: begin
            // A new sweep must be preceded by an all-off cycle, so L3 only accepts 000000.
            if (p == P_OFF) begin
               state_d     = IDLE;
               left_done_d = 1'b1;
            end else begin
               state_d = ERR;
            end
         end
         R1:   state_d = (p == P_R2) ? R2 : ERR;
         R2:   state_d = (p == P_R3) ? R3 : ERR;
         R3: begin
            if (p == P_OFF) begin
               state_d      = IDLE;
               right_done_d = 1'b1;
            end else begin
               state_d = ERR;
            end
         end
         ERR:  state_d = clr_err ? SYNC : ERR;
         SYNC: state_d = (p == P_OFF) ? IDLE : SYNC;
         default: state_d = ERR;
      endcase
   end

   // Clear has priority over a simultaneous completion; the done pulse is unaffected.
   always_comb begin
      left_cnt_d  = left_cnt_q;
      right_cnt_d = right_cnt_q;
      err_pulse_d = (state_d == ERR) && (state_q != ERR);
      if (clr_cnt) begin
         left_cnt_d  = '0;
         right_cnt_d = '0;
      end else begin
         if (left_done_d)  left_cnt_d  = left_cnt_q + 1'b1;
         if (right_done_d) right_cnt_d = right_cnt_q + 1'b1;
      end
   end

   assign left_active  = (state_q == L1) || (state_q == L2) || (state_q == L3);
   assign right_active = (state_q == R1) || (state_q == R2) || (state_q == R3);
   assign err          = (state_q == ERR);
   assign left_done    = left_done_q;
   assign right_done   = right_done_q;
   assign err_pulse    = err_pulse_q;
   assign left_count   = left_cnt_q;
   assign right_count  = right_cnt_q;

endmodule

// File: tb/tb_taillight_monitor.sv
// Directed bench for taillight_monitor: one default-width and one 2-bit-counter instance
// share the same lamp stimulus.
module tb_taillight_monitor;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic la = 0, lb = 0, lc = 0, ra = 0, rb = 0, rc = 0;
   logic clr_err = 0, clr_cnt = 0;

   logic       l_act, r_act, l_done, r_done, err_o, errp;
   logic [7:0] l_cnt, r_cnt;
   logic       l_act2, r_act2, l_done2, r_done2, err2, errp2;
   logic [1:0] l_cnt2, r_cnt2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   taillight_monitor dut (
      .clk(clk), .reset(reset),
      .la(la), .lb(lb), .lc(lc), .ra(ra), .rb(rb), .rc(rc),
      .clr_err(clr_err), .clr_cnt(clr_cnt),
      .left_active(l_act), .right_active(r_act),
      .left_done(l_done), .right_done(r_done),
      .left_count(l_cnt), .right_count(r_cnt),
      .err(err_o), .err_pulse(errp)
   );

   taillight_monitor #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset),
      .la(la), .lb(lb), .lc(lc), .ra(ra), .rb(rb), .rc(rc),
      .clr_err(clr_err), .clr_cnt(clr_cnt),
      .left_active(l_act2), .right_active(r_act2),
      .left_done(l_done2), .right_done(r_done2),
      .left_count(l_cnt2), .right_count(r_cnt2),
      .err(err2), .err_pulse(errp2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one pattern across a rising edge, then leave outputs settled 1 time unit later.
   task automatic cyc(input logic [5:0] p, input logic ce = 1'b0, input logic cc = 1'b0);
      {la, lb, lc, ra, rb, rc} = p;
      clr_err = ce;
      clr_cnt = cc;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
      clr_cnt = 1'b0;
   endtask

   task automatic left_sweep(input logic cc_last);
      cyc(6'b100000);
      cyc(6'b110000);
      cyc(6'b111000);
      cyc(6'b000000, 1'b0, cc_last);
   endtask

   // Packed view of all 1-bit outputs of the default instance: {l_act,r_act,l_done,r_done,err,errp}
   function automatic logic [5:0] flags();
      return {l_act, r_act, l_done, r_done, err_o, errp};
   endfunction

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_flags", {26'd0, flags()}, 32'd0);
      reset = 1'b0;
      repeat (3) cyc(6'b000000);
      chk("idle_flags", {26'd0, flags()}, 32'd0);
      chk("idle_counts", {16'd0, l_cnt, r_cnt}, 32'd0);

      // Left sweep
      cyc(6'b100000);
      chk("L1_flags", {26'd0, flags()}, 32'b100000);
      cyc(6'b110000);
      chk("L2_active", {31'd0, l_act}, 32'd1);
      cyc(6'b111000);
      chk("L3_active", {31'd0, l_act}, 32'd1);
      cyc(6'b000000);
      chk("L_done_flags", {26'd0, flags()}, 32'b001000);
      chk("L_count1", {24'd0, l_cnt}, 32'd1);
      cyc(6'b000000);
      chk("L_done_one_cycle", {31'd0, l_done}, 32'd0);

      // Two back-to-back right sweeps with one all-off cycle between
      cyc(6'b000100);
      chk("R1_flags", {26'd0, flags()}, 32'b010000);
      cyc(6'b000110);
      cyc(6'b000111);
      chk("R3_active", {31'd0, r_act}, 32'd1);
      cyc(6'b000000);
      chk("R_done_a", {26'd0, flags()}, 32'b000100);
      cyc(6'b000100);
      chk("R_done_a_cleared", {26'd0, flags()}, 32'b010000);
      cyc(6'b000110);
      cyc(6'b000111);
      cyc(6'b000000);
      chk("R_done_b", {26'd0, flags()}, 32'b000100);
      chk("R_count2", {24'd0, r_cnt}, 32'd2);

      // Illegal transition L1 -> 111000
      cyc(6'b100000);
      cyc(6'b111000);
      chk("err_entry", {26'd0, flags()}, 32'b000011);
      cyc(6'b000000);
      chk("err_hold", {26'd0, flags()}, 32'b000010);
      cyc(6'b110000, 1'b1);
      chk("sync_no_err", {26'd0, flags()}, 32'd0);
      cyc(6'b111000);
      chk("sync_wait", {26'd0, flags()}, 32'd0);
      cyc(6'b000000);
      cyc(6'b100000);
      chk("idle_after_sync", {26'd0, flags()}, 32'b100000);
      cyc(6'b110000);
      cyc(6'b111000);
      // L3 seeing 100000 (no off cycle) is illegal
      cyc(6'b100000);
      chk("L3_no_gap_err", {26'd0, flags()}, 32'b000011);
      chk("L3_err_no_count", {24'd0, l_cnt}, 32'd1);
      cyc(6'b000000, 1'b1);
      cyc(6'b000000);

      // Both sides lit in IDLE with clr_err on the same edge: ERR entered and held
      cyc(6'b100100, 1'b1);
      chk("both_lit_err", {26'd0, flags()}, 32'b000011);
      cyc(6'b000000);
      chk("clr_on_entry_ignored", {31'd0, err_o}, 32'd1);
      cyc(6'b000000, 1'b1);
      cyc(6'b000000);
      chk("recovered_idle", {26'd0, flags()}, 32'd0);

      // Counter clear, then wrap on the 2-bit instance
      cyc(6'b000000, 1'b0, 1'b1);
      chk("clr_cnt_both", {16'd0, l_cnt, r_cnt}, 32'd0);
      chk("clr_cnt_dut2", {28'd0, l_cnt2, r_cnt2}, 32'd0);
      left_sweep(1'b0);
      chk("wrap_1", {30'd0, l_cnt2}, 32'd1);
      left_sweep(1'b0);
      chk("wrap_2", {30'd0, l_cnt2}, 32'd2);
      left_sweep(1'b0);
      chk("wrap_3", {30'd0, l_cnt2}, 32'd3);
      left_sweep(1'b0);
      chk("wrap_0", {30'd0, l_cnt2}, 32'd0);
      chk("nowrap_4", {24'd0, l_cnt}, 32'd4);

      // clr_cnt on the completion edge
      left_sweep(1'b1);
      chk("clr_win_count", {24'd0, l_cnt}, 32'd0);
      chk("clr_win_count2", {30'd0, l_cnt2}, 32'd0);
      chk("clr_win_done", {31'd0, l_done}, 32'd1);

      // Asynchronous reset in L2
      cyc(6'b000000);
      cyc(6'b100000);
      cyc(6'b110000);
      reset = 1'b1;
      #2;
      chk("reset_mid_flags", {26'd0, flags()}, 32'd0);
      chk("reset_mid_count", {16'd0, l_cnt, r_cnt}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc(6'b000000);
      left_sweep(1'b0);
      chk("post_reset_count", {24'd0, l_cnt}, 32'd1);
      chk("post_reset_done", {31'd0, l_done}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
